// File: rtl/vga_rect_fill.sv
// rtl/vga_rect_fill.sv - bus-mapped rectangle fill engine driving frame buffer port A
// Optional completion interrupt and sticky done flag: define VGA_FILL_IRQ_EN.
module vga_rect_fill #(
  parameter logic [7:0] BASE_ADDR = 8'hB8,
  parameter int         H_PIXELS  = 160,
  parameter int         V_PIXELS  = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  inout  wire  [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  output logic [14:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  output logic        FB_WE,
`ifdef VGA_FILL_IRQ_EN
  output logic        BUSY,
  output logic        FILL_IRQ
`else
  output logic        BUSY
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  localparam logic [7:0] X_MAX = 8'(H_PIXELS - 1);
  localparam logic [7:0] Y_MAX = 8'(V_PIXELS - 1);

  state_t state, state_nxt;

  // Programmer-visible registers keep the raw written values
  logic [7:0] x0_reg, y0_reg, x1_reg, y1_reg;
  logic       colour;

  // Clamped working copy taken when a fill starts
  logic [7:0] wx0, wx1;
  logic [6:0] wy0, wy1;

  logic [7:0] cx;
  logic [6:0] cy;

  logic [7:0] offset;
  logic       hit, wr_en, rd_en, start;
  logic       rd_oe;
  logic [7:0] rd_data;
  logic       status_bit1;
  logic       rect_empty, last_pixel;
  logic       irq_int;

  function automatic logic [7:0] clamp_x(input logic [7:0] v);
    return (v > X_MAX) ? X_MAX : v;
  endfunction

  function automatic logic [6:0] clamp_y(input logic [7:0] v);
    logic [7:0] c;
    c = (v > Y_MAX) ? Y_MAX : v;
    return c[6:0];
  endfunction

  assign offset     = BUS_ADDR - BASE_ADDR;
  assign hit        = (offset < 8'd6);
  assign wr_en      = BUS_WE && hit && !BUSY;
  assign rd_en      = !BUS_WE && hit;
  assign start      = wr_en && (offset == 8'd4);
  assign rect_empty = (wx0 > wx1) || (wy0 > wy1);
  assign last_pixel = (cx == wx1) && (cy == wy1);

  assign FB_ADDR  = {cy, cx};
  assign FB_DATA  = {7'b0, colour};
  assign BUS_DATA = rd_oe ? rd_data : 8'bz;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-state outputs
  always_comb begin
    state_nxt = state;
    FB_WE     = 1'b0;
    BUSY      = 1'b1;
    irq_int   = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (start) state_nxt = SETUP;
      end
      SETUP: state_nxt = rect_empty ? DONE : FILL;
      FILL: begin
        FB_WE = 1'b1;
        if (last_pixel) state_nxt = DONE;
      end
      DONE: begin
        irq_int   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus register writes; ignored entirely while a fill is running
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x0_reg <= 8'd0;
      y0_reg <= 8'd0;
      x1_reg <= 8'd0;
      y1_reg <= 8'd0;
      colour <= 1'b0;
    end else if (wr_en) begin
      case (offset)
        8'd0: x0_reg <= BUS_DATA;
        8'd1: y0_reg <= BUS_DATA;
        8'd2: x1_reg <= BUS_DATA;
        8'd3: y1_reg <= BUS_DATA;
        8'd4: colour <= BUS_DATA[0];
        default: ;
      endcase
    end
  end

  // Latch clamped corners at the start command
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wx0 <= 8'd0;
      wx1 <= 8'd0;
      wy0 <= 7'd0;
      wy1 <= 7'd0;
    end else if (start) begin
      wx0 <= clamp_x(x0_reg);
      wx1 <= clamp_x(x1_reg);
      wy0 <= clamp_y(y0_reg);
      wy1 <= clamp_y(y1_reg);
    end
  end

  // Raster walk: cx wraps by compare against X1, cy steps once per row
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cx <= 8'd0;
      cy <= 7'd0;
    end else if (state == SETUP) begin
      cx <= wx0;
      cy <= wy0;
    end else if (state == FILL) begin
      if (cx == wx1) begin
        cx <= wx0;
        if (cy != wy1) cy <= cy + 7'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

`ifdef VGA_FILL_IRQ_EN
  logic done_flag;

  // Sticky done flag; completion wins over a simultaneous STATUS read
  always_ff @(posedge CLK) begin
    if (RESET)                           done_flag <= 1'b0;
    else if (state == DONE)              done_flag <= 1'b1;
    else if (rd_en && offset == 8'd5)    done_flag <= 1'b0;
  end

  assign status_bit1 = done_flag;
  assign FILL_IRQ    = irq_int;
`else
  assign status_bit1 = 1'b0;
`endif

  // Registered read data and output enable give one cycle of read latency
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_oe   <= 1'b0;
      rd_data <= 8'd0;
    end else begin
      rd_oe <= rd_en;
      case (offset)
        8'd0:    rd_data <= x0_reg;
        8'd1:    rd_data <= y0_reg;
        8'd2:    rd_data <= x1_reg;
        8'd3:    rd_data <= y1_reg;
        8'd4:    rd_data <= {7'b0, colour};
        8'd5:    rd_data <= {6'b0, status_bit1, BUSY};
        default: rd_data <= 8'd0;
      endcase
    end
  end

endmodule
